// File: rtl/cmp_window_monitor.sv
// cmp_window_monitor
//   Consumes one-hot comparator flag triples {gt, eq, lt} through a valid/ready
//   handshake. Samples are grouped into windows of WIN accepted triples. For each window
//   it tallies each legal outcome and each non-one-hot triple, and tracks the longest run
//   of identical legal outcomes. At the window end it publishes registered totals, a
//   majority code and a one-cycle done pulse.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_ena              block enable; low holds state and blocks acceptance
//   i_clear            synchronous clear of all state and results
//   i_in_valid         flag triple present
//   o_in_ready         triple can be accepted this cycle (depends on state and i_ena only)
//   i_gt, i_eq, i_lt   comparator flags
//   o_res_gt/eq/lt     tallies of the last completed window
//   o_res_err          non-one-hot triples in the last completed window
//   o_res_major        00 none/tie, 01 gt, 10 eq, 11 lt
//   o_res_streak       longest run of identical legal outcomes in the last window
//   o_win_done         one-cycle pulse when results update
module cmp_window_monitor #(
  parameter int unsigned WIN   = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_gt,
  input  logic             i_eq,
  input  logic             i_lt,
  output logic [CNT_W-1:0] o_res_gt,
  output logic [CNT_W-1:0] o_res_eq,
  output logic [CNT_W-1:0] o_res_lt,
  output logic [CNT_W-1:0] o_res_err,
  output logic [1:0]       o_res_major,
  output logic [CNT_W-1:0] o_res_streak,
  output logic             o_win_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  // Outcome codes share the encoding of o_res_major; 00 marks an illegal triple.
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_GT   = 2'b01;
  localparam logic [1:0] CODE_EQ   = 2'b10;
  localparam logic [1:0] CODE_LT   = 2'b11;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_gt, r_eq, r_lt, r_err;
  logic [CNT_W-1:0] r_run, r_max_run;
  logic [1:0]       r_prev;
  logic [CNT_W-1:0] r_res_gt, r_res_eq, r_res_lt, r_res_err, r_res_streak;
  logic [1:0]       r_res_major;
  logic             r_win_done;

  logic             w_accept;
  logic [1:0]       w_code;
  logic             w_legal;
  logic             w_last;
  logic [CNT_W-1:0] w_gt_nx, w_eq_nx, w_lt_nx, w_err_nx;
  logic [CNT_W-1:0] w_run_nx, w_max_nx;

  // A code wins only when strictly above both others; any tie at the top reports none.
  function automatic logic [1:0] f_major(input logic [CNT_W-1:0] g,
                                         input logic [CNT_W-1:0] e,
                                         input logic [CNT_W-1:0] l);
    logic [1:0] m;
    m = CODE_NONE;
    if (g > e && g > l) m = CODE_GT;
    else if (e > g && e > l) m = CODE_EQ;
    else if (l > g && l > e) m = CODE_LT;
    return m;
  endfunction

  assign o_in_ready = (r_state == ACCUM) && i_ena;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_last     = (r_win_cnt == CNT_W'(WIN - 1));

  always_comb begin
    w_code = CODE_NONE;
    case ({i_gt, i_eq, i_lt})
      3'b100:  w_code = CODE_GT;
      3'b010:  w_code = CODE_EQ;
      3'b001:  w_code = CODE_LT;
      default: w_code = CODE_NONE;
    endcase
  end

  assign w_legal = (w_code != CODE_NONE);

  // Working values including the sample currently offered; used for both the
  // running update and the final-sample result capture.
  always_comb begin
    w_gt_nx  = r_gt + CNT_W'(w_code == CODE_GT);
    w_eq_nx  = r_eq + CNT_W'(w_code == CODE_EQ);
    w_lt_nx  = r_lt + CNT_W'(w_code == CODE_LT);
    w_err_nx = r_err + CNT_W'(!w_legal);
    // r_prev is CODE_NONE after an illegal sample or window start, so it never matches.
    if (!w_legal) w_run_nx = '0;
    else if (w_code == r_prev) w_run_nx = r_run + CNT_W'(1);
    else w_run_nx = CNT_W'(1);
    w_max_nx = (w_run_nx > r_max_run) ? w_run_nx : r_max_run;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_gt         <= '0;
      r_eq         <= '0;
      r_lt         <= '0;
      r_err        <= '0;
      r_run        <= '0;
      r_max_run    <= '0;
      r_prev       <= CODE_NONE;
      r_res_gt     <= '0;
      r_res_eq     <= '0;
      r_res_lt     <= '0;
      r_res_err    <= '0;
      r_res_streak <= '0;
      r_res_major  <= CODE_NONE;
      r_win_done   <= 1'b0;
    end else if (i_clear) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_gt         <= '0;
      r_eq         <= '0;
      r_lt         <= '0;
      r_err        <= '0;
      r_run        <= '0;
      r_max_run    <= '0;
      r_prev       <= CODE_NONE;
      r_res_gt     <= '0;
      r_res_eq     <= '0;
      r_res_lt     <= '0;
      r_res_err    <= '0;
      r_res_streak <= '0;
      r_res_major  <= CODE_NONE;
      r_win_done   <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_ena) r_state <= ACCUM;
        end
        ACCUM: begin
          if (w_accept) begin
            r_win_cnt <= r_win_cnt + CNT_W'(1);
            r_gt      <= w_gt_nx;
            r_eq      <= w_eq_nx;
            r_lt      <= w_lt_nx;
            r_err     <= w_err_nx;
            r_run     <= w_run_nx;
            r_max_run <= w_max_nx;
            r_prev    <= w_code;
            if (w_last) begin
              r_res_gt     <= w_gt_nx;
              r_res_eq     <= w_eq_nx;
              r_res_lt     <= w_lt_nx;
              r_res_err    <= w_err_nx;
              r_res_streak <= w_max_nx;
              r_res_major  <= f_major(w_gt_nx, w_eq_nx, w_lt_nx);
              r_win_done   <= 1'b1;
              r_state      <= REPORT;
            end
          end
        end
        REPORT: begin
          r_win_cnt <= '0;
          r_gt      <= '0;
          r_eq      <= '0;
          r_lt      <= '0;
          r_err     <= '0;
          r_run     <= '0;
          r_max_run <= '0;
          r_prev    <= CODE_NONE;
          r_state   <= i_ena ? ACCUM : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_res_gt     = r_res_gt;
  assign o_res_eq     = r_res_eq;
  assign o_res_lt     = r_res_lt;
  assign o_res_err    = r_res_err;
  assign o_res_streak = r_res_streak;
  assign o_res_major  = r_res_major;
  assign o_win_done   = r_win_done;

endmodule

// File: tb/tb_cmp_window_monitor.sv
`timescale 1ns/1ps
module tb_cmp_window_monitor;
  localparam int unsigned WIN   = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst, ena, clear, in_valid, gt, eq, lt;
  logic in_ready, win_done;
  logic [CNT_W-1:0] res_gt, res_eq, res_lt, res_err, res_streak;
  logic [1:0] res_major;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [CNT_W-1:0] g, e, l, err, streak;
    logic [1:0]       maj;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  always #5 clk = ~clk;

  cmp_window_monitor #(.WIN(WIN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_clear(clear),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_gt(gt), .i_eq(eq), .i_lt(lt),
    .o_res_gt(res_gt), .o_res_eq(res_eq), .o_res_lt(res_lt), .o_res_err(res_err),
    .o_res_major(res_major), .o_res_streak(res_streak), .o_win_done(win_done)
  );

  // Reference model of one window; element 0 is the first sample, triple = {gt,eq,lt}.
  function automatic exp_t model(input logic [0:3][2:0] smp);
    exp_t r;
    int g = 0, e = 0, l = 0, err = 0, run = 0, mx = 0, prev = 0, c;
    for (int i = 0; i < 4; i++) begin
      case (smp[i])
        3'b100:  c = 1;
        3'b010:  c = 2;
        3'b001:  c = 3;
        default: c = 0;
      endcase
      if (c == 0) begin
        err++; run = 0; prev = 0;
      end else begin
        if (c == 1) g++;
        if (c == 2) e++;
        if (c == 3) l++;
        run  = (c == prev) ? run + 1 : 1;
        prev = c;
      end
      if (run > mx) mx = run;
    end
    r.g = CNT_W'(g); r.e = CNT_W'(e); r.l = CNT_W'(l);
    r.err = CNT_W'(err); r.streak = CNT_W'(mx);
    if (g > e && g > l) r.maj = 2'b01;
    else if (e > g && e > l) r.maj = 2'b10;
    else if (l > g && l > e) r.maj = 2'b11;
    else r.maj = 2'b00;
    return r;
  endfunction

  // Scoreboard: every window-done pulse pops one expected window.
  always @(negedge clk) begin
    if (win_done === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_win_done: got pulse, expected none");
      end else begin
        mon_x = sb.pop_front();
        if (res_gt !== mon_x.g) begin
          n_fail++; $display("FAIL res_gt: got %0d expected %0d", res_gt, mon_x.g);
        end
        n_tests++;
        if (res_eq !== mon_x.e) begin
          n_fail++; $display("FAIL res_eq: got %0d expected %0d", res_eq, mon_x.e);
        end
        n_tests++;
        if (res_lt !== mon_x.l) begin
          n_fail++; $display("FAIL res_lt: got %0d expected %0d", res_lt, mon_x.l);
        end
        n_tests++;
        if (res_err !== mon_x.err) begin
          n_fail++; $display("FAIL res_err: got %0d expected %0d", res_err, mon_x.err);
        end
        n_tests++;
        if (res_streak !== mon_x.streak) begin
          n_fail++; $display("FAIL res_streak: got %0d expected %0d", res_streak, mon_x.streak);
        end
        n_tests++;
        if (res_major !== mon_x.maj) begin
          n_fail++; $display("FAIL res_major: got %b expected %b", res_major, mon_x.maj);
        end
      end
    end
  end

  // Offer one triple and hold it until accepted (bounded).
  task automatic send(input logic [2:0] t);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      {gt, eq, lt} = t;
      in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end else begin
      n_tests++; n_fail++;
      in_valid = 1'b0;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic feed(input logic [0:3][2:0] smp);
    sb.push_back(model(smp));
    for (int i = 0; i < 4; i++) send(smp[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b0; clear = 1'b0; in_valid = 1'b0;
    gt = 1'b0; eq = 1'b0; lt = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_tests++;
    if (win_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_win_done: got %b expected 0", win_done);
    end
    n_tests++;
    if ({res_gt, res_eq, res_lt, res_err, res_streak, res_major} !== '0) begin
      n_fail++;
      $display("FAIL reset_results: got %0d/%0d/%0d/%0d/%0d/%b expected all 0",
               res_gt, res_eq, res_lt, res_err, res_streak, res_major);
    end
    @(posedge clk);
    #1 rst = 1'b0; ena = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_in_ready: got %b expected 0", in_ready);
    end
  endtask

  task automatic test_basic;
    time t0, t1;
    sb.push_back(model({3'b100, 3'b100, 3'b010, 3'b001}));
    send(3'b100);
    t0 = $time;
    send(3'b100); send(3'b010); send(3'b001);
    @(negedge clk);
    t1 = $time;
    n_tests++;
    if (win_done !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: got %b expected 1", win_done);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL report_in_ready: got %b expected 0", in_ready);
    end
    n_tests++;
    if (t1 - t0 != 34) begin
      n_fail++; $display("FAIL basic_latency: got %0t expected 34", t1 - t0);
    end
    @(negedge clk);
    n_tests++;
    if (win_done !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle: got %b expected 0", win_done);
    end
  endtask

  task automatic test_back_to_back;
    feed({3'b010, 3'b010, 3'b001, 3'b001});
    feed({3'b001, 3'b111, 3'b001, 3'b000});
  endtask

  task automatic test_ena_pause;
    time t0, t1;
    sb.push_back(model({3'b100, 3'b100, 3'b010, 3'b001}));
    send(3'b100);
    t0 = $time;
    send(3'b100);
    ena = 1'b0; in_valid = 1'b1; {gt, eq, lt} = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL ena_low_in_ready: got %b expected 0", in_ready);
      end
    end
    @(posedge clk);
    #1 ena = 1'b1; in_valid = 1'b0;
    send(3'b010); send(3'b001);
    @(negedge clk);
    t1 = $time;
    n_tests++;
    if (win_done !== 1'b1 || t1 - t0 != 64) begin
      n_fail++;
      $display("FAIL ena_pause_latency: got done=%b after %0t expected done=1 after 64",
               win_done, t1 - t0);
    end
  endtask

  task automatic test_reset_mid;
    send(3'b100); send(3'b010); send(3'b001);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({res_gt, res_eq, res_lt, res_err, res_streak, res_major, win_done, in_ready} !== '0)
    begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %0d/%0d/%0d/%0d/%0d/%b done=%b rdy=%b expected 0",
               res_gt, res_eq, res_lt, res_err, res_streak, res_major, win_done, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    feed({3'b001, 3'b001, 3'b001, 3'b010});
  endtask

  task automatic test_clear_report;
    feed({3'b010, 3'b010, 3'b010, 3'b100});
    clear = 1'b1; in_valid = 1'b1; {gt, eq, lt} = 3'b100;
    @(negedge clk);
    n_tests++;
    if (win_done !== 1'b1) begin
      n_fail++; $display("FAIL clear_report_done: got %b expected 1", win_done);
    end
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({res_gt, res_eq, res_lt, res_err, res_streak, res_major, win_done} !== '0) begin
      n_fail++;
      $display("FAIL clear_outputs: got %0d/%0d/%0d/%0d/%0d/%b done=%b expected 0",
               res_gt, res_eq, res_lt, res_err, res_streak, res_major, win_done);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_idle_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_then_accum: got %b expected 1", in_ready);
    end
    feed({3'b100, 3'b001, 3'b100, 3'b100});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ena_pause();
    test_reset_mid();
    test_clear_report();
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL windows_pending: got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
